timer_tick_master: RTL
======================

# timer_tick_master

Avalon-MM initiator that owns the 16-bit interval timer slave and services its interrupt in hardware. It enables the timer IRQ and acknowledges each timeout by writing the status register. It then latches and reads the counter snapshot and publishes a running tick count with a one-cycle tick strobe. It sits between the timer's s1 slave/irq pins and fabric logic that needs a periodic tick without CPU involvement.

## Interface
Parameters:
- READ_LATENCY, 1: fixed slave read latency in cycles (≥1); the timer slave registers readdata, hence 1.
- CNT_W, 32: width of tick_count.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  level; 1 = run the timer service, 0 = disable the timer IRQ and idle.
- cnt_clear  in  1  synchronous clear of tick_count.
- irq  in  1  timer interrupt, level.
- avm_address  out  3  word address: 0 status, 1 control, 4 snap_l.
- avm_chipselect  out  1  transfer request.
- avm_write_n  out  1  0 = write, 1 = read when chipselect=1.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  read data, valid READ_LATENCY cycles after read accept.
- avm_waitrequest  in  1  slave stall; tie 0 for the timer.
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  CNT_W  serviced timeouts since reset/clear, wraps.
- snapshot  out  16  last snapshot read (counter value at latch time).
- busy  out  1  1 whenever state ≠ IDLE.

## Operation
- All outputs are registered. Reset values: avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, tick 0, tick_count 0, snapshot 0, busy 0; the FSM resets to IDLE.
- A transfer is accepted on the first cycle with chipselect=1 and waitrequest=0. While stalled, address, write_n and writedata are held constant. chipselect drops the cycle after acceptance unless the next state issues a transfer.
- FSM:
  - IDLE: if enable=1 → EN_WR.
  - EN_WR: write addr 1, data 0x0001 → WAIT_IRQ.
  - WAIT_IRQ: no transfer. If enable=0 → DIS_WR. Else if irq=1 → CLR_WR.
  - CLR_WR: write addr 0, data 0x0000, which clears timeout_occurred → SNAP_WR.
  - SNAP_WR: write addr 4, data 0x0000, which latches the counter → SNAP_RD.
  - SNAP_RD: read addr 4 → WAIT_DATA.
  - WAIT_DATA: lasts READ_LATENCY cycles, then captures avm_readdata into snapshot, increments tick_count, pulses tick → WAIT_IRQ.
  - DIS_WR: write addr 1, data 0x0000 → IDLE.
- enable is sampled only in IDLE and WAIT_IRQ. Dropping enable mid-service completes the service sequence, including the tick, before the disable write.
- irq is sampled only in WAIT_IRQ. An irq that reasserts before the FSM returns to WAIT_IRQ is serviced on return, because the level stays high.
- tick_count increments modulo 2^CNT_W; 0xFFFFFFFF → 0 with tick=1.
- cnt_clear=1: tick_count ← 0. If cnt_clear and an increment occur in the same cycle, tick_count ← 1.
- reset_n=0 mid-transfer: on the next edge, outputs take reset values and a pending transfer is abandoned. The slave keeps its own state, so after reset the FSM re-runs EN_WR.

## Timing
- With waitrequest=0 and READ_LATENCY=1, counting from the cycle n in which WAIT_IRQ samples irq=1:
  - n+1: CLR_WR (addr 0 write on the bus).
  - n+2: SNAP_WR.
  - n+3: SNAP_RD.
  - n+4: WAIT_DATA (readdata valid, captured at end of n+4).
  - n+5: tick=1 with updated snapshot and tick_count; state is WAIT_IRQ.
- The timer's irq falls from n+2, so the service does not retrigger.
- Each waitrequest cycle on an accepted-pending transfer adds exactly one cycle. Larger READ_LATENCY adds READ_LATENCY−1 cycles.
- From reset release with enable=1: IDLE at cycle 0, EN_WR write on the bus at cycle 1, WAIT_IRQ at cycle 2.
- Minimum tick spacing is 5 cycles.

## Test plan
- Bring-up: reset, enable=1 → single write addr 1 data 0x0001 at cycle 1; busy=1 from cycle 1; no further bus activity while irq=0.
- Service: timer model with counter 0x1234 at the snap write, irq high at cycle n → bus sequence W0/0x0000, W4, R4 at n+1..n+3; tick at n+5; snapshot=0x1234; tick_count=1.
- Stall: waitrequest high for 3 cycles on CLR_WR → address/data held stable; tick at n+8; exactly one write accepted.
- Disable: enable→0 at n+2 of a service → tick still at n+5, then write addr 1 data 0x0000, then IDLE with busy=0.
- Wrap and clear: preload tick_count=0xFFFFFFFF via repeated ticks or force → next tick gives 0. Assert cnt_clear on a tick cycle → tick_count=1.
- Reset mid-read: reset_n=0 during SNAP_RD → next edge chipselect=0, tick_count=0, snapshot=0. Release with enable=1 → EN_WR reissued.

Source files
------------

// File: rtl/timer_tick_master.sv
// Avalon-MM initiator that services the 16-bit interval timer interrupt in
// hardware: it enables the timer IRQ, acknowledges each timeout, latches and
// reads the counter snapshot, and publishes a running tick count with a strobe.
module timer_tick_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cnt_clear,
  input  logic             irq,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             avm_waitrequest,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic [15:0]      snapshot,
  output logic             busy
);

  localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(READ_LATENCY - 1);

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrControl = 3'd1;
  localparam logic [2:0] AddrSnapL   = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StEnWr,
    StWaitIrq,
    StClrWr,
    StSnapWr,
    StSnapRd,
    StWaitData,
    StDisWr
  } state_e;

  state_e state_q, state_d;
  logic [LatW-1:0] lat_q, lat_d;

  logic             cs_d;
  logic             write_n_d;
  logic [2:0]       address_d;
  logic [15:0]      writedata_d;
  logic             tick_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;
  logic [15:0]      snapshot_d;
  logic             busy_d;

  logic xfer_done;
  logic lat_done;

  // A transfer state only advances once the slave has accepted the request.
  assign xfer_done = avm_chipselect & ~avm_waitrequest;
  assign lat_done  = (state_q == StWaitData) && (lat_q == LatLast);

  // State register and read-latency counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state decode for the service sequence.
  always_comb begin
    state_d = state_q;
    lat_d   = (state_q == StWaitData) ? lat_q + LatW'(1) : '0;
    unique case (state_q)
      StIdle:     if (enable) state_d = StEnWr;
      StEnWr:     if (xfer_done) state_d = StWaitIrq;
      StWaitIrq: begin
        if (!enable)  state_d = StDisWr;
        else if (irq) state_d = StClrWr;
      end
      StClrWr:    if (xfer_done) state_d = StSnapWr;
      StSnapWr:   if (xfer_done) state_d = StSnapRd;
      StSnapRd:   if (xfer_done) state_d = StWaitData;
      StWaitData: if (lat_done) state_d = StWaitIrq;
      StDisWr:    if (xfer_done) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Bus request for the upcoming state; a stall keeps state_d equal to state_q,
  // so address/data are naturally held. Address and data hold when idle.
  always_comb begin
    cs_d        = 1'b0;
    write_n_d   = 1'b1;
    address_d   = avm_address;
    writedata_d = avm_writedata;
    unique case (state_d)
      StEnWr: begin
        cs_d        = 1'b1;
        write_n_d   = 1'b0;
        address_d   = AddrControl;
        writedata_d = 16'h0001;
      end
      StClrWr: begin
        cs_d        = 1'b1;
        write_n_d   = 1'b0;
        address_d   = AddrStatus;
        writedata_d = 16'h0000;
      end
      StSnapWr: begin
        cs_d        = 1'b1;
        write_n_d   = 1'b0;
        address_d   = AddrSnapL;
        writedata_d = 16'h0000;
      end
      StSnapRd: begin
        cs_d        = 1'b1;
        write_n_d   = 1'b1;
        address_d   = AddrSnapL;
      end
      StDisWr: begin
        cs_d        = 1'b1;
        write_n_d   = 1'b0;
        address_d   = AddrControl;
        writedata_d = 16'h0000;
      end
      default: ;
    endcase
  end

  // Tick, snapshot and counter next values; clear wins except over a
  // coincident increment, which leaves the count at one.
  always_comb begin
    tick_d     = lat_done;
    snapshot_d = lat_done ? avm_readdata : snapshot;
    busy_d     = (state_d != StIdle);
    if (cnt_clear) begin
      tick_count_d = lat_done ? CNT_W'(1) : '0;
    end else if (lat_done) begin
      tick_count_d = tick_count_q + CNT_W'(1);
    end else begin
      tick_count_d = tick_count_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      tick           <= 1'b0;
      tick_count_q   <= '0;
      snapshot       <= '0;
      busy           <= 1'b0;
    end else begin
      avm_chipselect <= cs_d;
      avm_write_n    <= write_n_d;
      avm_address    <= address_d;
      avm_writedata  <= writedata_d;
      tick           <= tick_d;
      tick_count_q   <= tick_count_d;
      snapshot       <= snapshot_d;
      busy           <= busy_d;
    end
  end

  assign tick_count = tick_count_q;

endmodule
